// File: rtl/vec_mem_stage.sv
// vec_mem_stage: vector memory stage behind Execute. A vector load or store
// is moved one lane per cycle through a single-port N-bit data memory. The
// pipeline is stalled until the transfer finishes. DoneM pulses for one cycle
// when the transfer ends, and ReadDataM carries the load result.
// Optional build macro: VMEM_LANE_MASK_EN adds the LaneMaskM per-lane enable.
module vec_mem_stage #(
    parameter int N     = 20,
    parameter int LANES = 8,
    parameter int AW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemWriteM,
    input  logic                    MemReadM,
`ifdef VMEM_LANE_MASK_EN
    input  logic [LANES-1:0]        LaneMaskM,
`endif
    input  logic [LANES-1:0][N-1:0] ALUResultM,
    input  logic [LANES-1:0][N-1:0] WriteDataM,
    output logic [LANES-1:0][N-1:0] ReadDataM,
    output logic                    StallM,
    output logic                    DoneM,
    output logic [AW-1:0]           mem_addr,
    output logic [N-1:0]            mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [N-1:0]            mem_rdata
);
    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        LOAD_LAST,
        DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [KW-1:0]               k_reg, k_next;
    logic [AW-1:0]               base_reg;
    logic [LANES-1:0][N-1:0]     wdata_reg;
    logic [LANES-2:0][N-1:0]     buf_reg;      // lanes 0..LANES-2; the last lane goes straight to the result
    logic [LANES-1:0][N-1:0]     rdata_reg;
    logic [LANES-1:0][N-1:0]     lane_in;
    logic [LANES-1:0][N-1:0]     rdata_final;
    logic [LANES-1:0]            mask_reg;
    logic [LANES-1:0]            mask_in;
    logic [LANES-2:0]            cap;
    logic                        k_last;
    logic                        unused_bits;

`ifdef VMEM_LANE_MASK_EN
    assign mask_in = LaneMaskM;
`else
    assign mask_in = '1;
`endif

    // Only the low AW bits of lane 0 form the address. The remaining ALU bits are not needed here.
    assign unused_bits = ^{ALUResultM[LANES-1:1], ALUResultM[0][N-1:AW]};

    assign k_last    = (k_reg == KW'(LANES - 1));
    assign ReadDataM = rdata_reg;

    // Read data arriving in a LOAD cycle belongs to the lane issued one cycle earlier.
    // Masked-off lanes return zero.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi] = mask_reg[gi] ? mem_rdata : '0;
            if (gi == LANES - 1) begin : g_last
                assign rdata_final[gi] = lane_in[gi];
            end else begin : g_mid
                assign cap[gi]         = (state_reg == LOAD) && (k_reg == KW'(gi + 1));
                assign rdata_final[gi] = buf_reg[gi];
            end
        end
    endgenerate

    // State register and lane counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    // Next-state logic and memory/pipeline control outputs.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        StallM     = 1'b0;
        DoneM      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                // The first cycle of a request already stalls. A store wins over a load.
                StallM = ~rst & (MemWriteM | MemReadM);
                k_next = '0;
                if (MemWriteM)
                    state_next = STORE;
                else if (MemReadM)
                    state_next = LOAD;
            end
            STORE: begin
                StallM    = 1'b1;
                mem_addr  = base_reg + AW'(k_reg);
                mem_wdata = wdata_reg[k_reg];
                mem_we    = mask_reg[k_reg];
                if (k_last)
                    state_next = DONE;
                else
                    k_next = k_reg + 1'b1;
            end
            LOAD: begin
                StallM   = 1'b1;
                mem_addr = base_reg + AW'(k_reg);
                mem_re   = mask_reg[k_reg];
                if (k_last)
                    state_next = LOAD_LAST;
                else
                    k_next = k_reg + 1'b1;
            end
            LOAD_LAST: begin
                StallM     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                DoneM      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, load lane capture, and result publication on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg  <= '0;
            mask_reg  <= '0;
            wdata_reg <= '0;
            buf_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && (MemWriteM || MemReadM)) begin
                base_reg <= ALUResultM[0][AW-1:0];
                mask_reg <= mask_in;
            end
            if ((state_reg == IDLE) && MemWriteM)
                wdata_reg <= WriteDataM;
            for (int i = 0; i < LANES - 1; i++) begin
                if (cap[i])
                    buf_reg[i] <= lane_in[i];
            end
            if (state_reg == LOAD_LAST)
                rdata_reg <= rdata_final;
        end
    end
endmodule

// File: tb/tb_vec_mem_stage.sv
// Testbench for vec_mem_stage. A small memory model answers the memory port.
// A scoreboard queue holds the expected memory accesses. Each test task checks
// stall, done and load-result timing inline.
`timescale 1ns/1ps
module tb_vec_mem_stage;
    localparam int N     = 20;
    localparam int LANES = 8;
    localparam int AW    = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    MemWriteM, MemReadM;
    logic [LANES-1:0][N-1:0] ALUResultM, WriteDataM, ReadDataM;
    logic                    StallM, DoneM, mem_we, mem_re;
    logic [AW-1:0]           mem_addr;
    logic [N-1:0]            mem_wdata, mem_rdata;
`ifdef VMEM_LANE_MASK_EN
    logic [LANES-1:0]        LaneMaskM;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    logic [N-1:0] mem [0:(1<<AW)-1];

    vec_mem_stage #(.N(N), .LANES(LANES), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
`ifdef VMEM_LANE_MASK_EN
        .LaneMaskM  (LaneMaskM),
`endif
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .DoneM      (DoneM),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on the edge, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Scoreboard monitor: every memory access must match the next expected entry.
    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            tests++; fails++;
            $display("FAIL we_re_exclusive: both high at addr %h", mem_addr);
        end
        if (mem_we || mem_re) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL mem_access: unexpected we=%b re=%b addr=%h, none required", mem_we, mem_re, mem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || (mon_e.we && mem_wdata !== mon_e.data)) begin
                    fails++;
                    $display("FAIL mem_access: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                             mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Queue the memory accesses the DUT is required to make for one vector transfer.
    task automatic push(input logic we, input logic [AW-1:0] base,
                        input logic [LANES-1:0][N-1:0] d, input logic [LANES-1:0] m);
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                e.we   = we;
                e.addr = base + AW'(i);
                e.data = we ? d[i] : '0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Run one transfer from its request cycle. Record StallM/DoneM per cycle and
    // ReadDataM at DoneM, then present the next request. Bounded to 16 cycles.
    task automatic record(input logic nwe, input logic nre, input logic [AW-1:0] nbase,
                          output logic [15:0] st, output logic [15:0] dn,
                          output logic [LANES-1:0][N-1:0] rd);
        logic fin;
        fin = 1'b0;
        st  = '0;
        dn  = '0;
        rd  = '0;
        for (int c = 0; c < 16 && !fin; c++) begin
            #1;
            st[c] = StallM;
            dn[c] = DoneM;
            if (DoneM) begin
                rd            = ReadDataM;
                MemWriteM     = nwe;
                MemReadM      = nre;
                ALUResultM[0] = N'(nbase);
                fin           = 1'b1;
            end else if (c == 1) begin
                // The inputs are latched by now, so later input changes must have no effect.
                for (int i = 0; i < LANES; i++) begin
                    ALUResultM[i] = N'($urandom);
                    WriteDataM[i] = N'($urandom);
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            MemWriteM = 1'b0;
            MemReadM  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemWriteM = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({StallM, DoneM, mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got stall=%b done=%b we=%b re=%b addr=%h wdata=%h, required all 0",
                     StallM, DoneM, mem_we, mem_re, mem_addr, mem_wdata);
        end
        tests++;
        if (ReadDataM !== '0) begin
            fails++;
            $display("FAIL reset_readdata: got %h required 0", ReadDataM);
        end
        MemWriteM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (StallM !== 1'b0 || DoneM !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got stall=%b done=%b required 0 0", StallM, DoneM);
        end
        $display("[TB] reset check complete");
        @(negedge clk);
    endtask

    task automatic test_store();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, wd, prev;
        for (int i = 0; i < LANES; i++) wd[i] = N'(20'h00100 + i);
        prev = ReadDataM;
        push(1'b1, 16'h0010, wd, '1);
        MemWriteM = 1'b1; MemReadM = 1'b0;
        ALUResultM[0] = N'(16'h0010); WriteDataM = wd;
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (st !== 16'h01FF) begin fails++; $display("FAIL store_stall: got %h required %h", st, 16'h01FF); end
        tests++;
        if (dn !== 16'h0200) begin fails++; $display("FAIL store_done: got %h required %h", dn, 16'h0200); end
        tests++;
        if (rd !== prev) begin fails++; $display("FAIL store_readdata_held: got %h required %h", rd, prev); end
        #1;
        tests++;
        if (StallM !== 1'b0 || DoneM !== 1'b0) begin
            fails++;
            $display("FAIL store_after_idle: got stall=%b done=%b required 0 0", StallM, DoneM);
        end
        $display("[TB] store base=0010 done mask=%h", dn);
    endtask

    task automatic test_load();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, ex;
        for (int i = 0; i < LANES; i++) ex[i] = N'(20'hA0000 + i);
        push(1'b0, 16'h0020, ex, '1);
        MemWriteM = 1'b0; MemReadM = 1'b1;
        ALUResultM[0] = N'(16'h0020);
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (st !== 16'h03FF) begin fails++; $display("FAIL load_stall: got %h required %h", st, 16'h03FF); end
        tests++;
        if (dn !== 16'h0400) begin fails++; $display("FAIL load_done: got %h required %h", dn, 16'h0400); end
        tests++;
        if (rd !== ex) begin fails++; $display("FAIL load_data: got %h required %h", rd, ex); end
        $display("[TB] load base=0020 data=%h", rd);
    endtask

    task automatic test_wrap();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, wd;
        for (int i = 0; i < LANES; i++) wd[i] = N'(20'h3C000 + i);
        push(1'b1, 16'hFFFE, wd, '1);
        MemWriteM = 1'b1; MemReadM = 1'b0;
        ALUResultM[0] = N'(16'hFFFE); WriteDataM = wd;
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (dn !== 16'h0200) begin fails++; $display("FAIL wrap_done: got %h required %h", dn, 16'h0200); end
        tests++;
        if (mem[16'hFFFF] !== 20'h3C001) begin fails++; $display("FAIL wrap_ffff: got %h required 3c001", mem[16'hFFFF]); end
        tests++;
        if (mem[16'h0000] !== 20'h3C002) begin fails++; $display("FAIL wrap_0000: got %h required 3c002", mem[16'h0000]); end
        tests++;
        if (mem[16'h0005] !== 20'h3C007) begin fails++; $display("FAIL wrap_0005: got %h required 3c007", mem[16'h0005]); end
        $display("[TB] wrap store base=fffe done");
    endtask

    task automatic test_simultaneous();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, wd, prev;
        for (int i = 0; i < LANES; i++) wd[i] = N'(20'h40400 + i);
        prev = ReadDataM;
        push(1'b1, 16'h0040, wd, '1);
        MemWriteM = 1'b1; MemReadM = 1'b1;
        ALUResultM[0] = N'(16'h0040); WriteDataM = wd;
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (st !== 16'h01FF) begin fails++; $display("FAIL simul_stall: got %h required %h", st, 16'h01FF); end
        tests++;
        if (dn !== 16'h0200) begin fails++; $display("FAIL simul_done: got %h required %h", dn, 16'h0200); end
        tests++;
        if (rd !== prev) begin fails++; $display("FAIL simul_readdata_held: got %h required %h", rd, prev); end
        $display("[TB] simultaneous request base=0040 handled as store");
    endtask

    task automatic test_back_to_back();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, wd;
        for (int i = 0; i < LANES; i++) wd[i] = N'(20'h55000 + i);
        push(1'b1, 16'h0050, wd, '1);
        push(1'b0, 16'h0050, wd, '1);
        MemWriteM = 1'b1; MemReadM = 1'b0;
        ALUResultM[0] = N'(16'h0050); WriteDataM = wd;
        record(1'b0, 1'b1, 16'h0050, st, dn, rd);
        tests++;
        if (dn !== 16'h0200) begin fails++; $display("FAIL b2b_store_done: got %h required %h", dn, 16'h0200); end
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (st !== 16'h03FF) begin fails++; $display("FAIL b2b_load_stall: got %h required %h", st, 16'h03FF); end
        tests++;
        if (dn !== 16'h0400) begin fails++; $display("FAIL b2b_load_done: got %h required %h", dn, 16'h0400); end
        tests++;
        if (rd !== wd) begin fails++; $display("FAIL b2b_load_data: got %h required %h", rd, wd); end
        $display("[TB] back-to-back store/load base=0050 data=%h", rd);
    endtask

    task automatic test_reset_mid();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, wd, ex;
        for (int i = 0; i < LANES; i++) begin
            wd[i] = N'(20'h77000 + i);
            ex[i] = N'(20'hA0000 + i);
        end
        push(1'b1, 16'h0030, wd, 8'b0000_0111);
        MemWriteM = 1'b1; MemReadM = 1'b0;
        ALUResultM[0] = N'(16'h0030); WriteDataM = wd;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({StallM, DoneM, mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got stall=%b done=%b we=%b re=%b addr=%h wdata=%h, required all 0",
                     StallM, DoneM, mem_we, mem_re, mem_addr, mem_wdata);
        end
        tests++;
        if (ReadDataM !== '0) begin fails++; $display("FAIL midreset_readdata: got %h required 0", ReadDataM); end
        @(negedge clk);
        MemWriteM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(1'b0, 16'h0020, ex, '1);
        MemReadM = 1'b1;
        ALUResultM[0] = N'(16'h0020);
        record(1'b0, 1'b0, '0, st, dn, rd);
        tests++;
        if (dn !== 16'h0400) begin fails++; $display("FAIL midreset_load_done: got %h required %h", dn, 16'h0400); end
        tests++;
        if (rd !== ex) begin fails++; $display("FAIL midreset_load_data: got %h required %h", rd, ex); end
        $display("[TB] reset mid-store then load base=0020 data=%h", rd);
    endtask

`ifdef VMEM_LANE_MASK_EN
    task automatic test_mask();
        logic [15:0] st, dn;
        logic [LANES-1:0][N-1:0] rd, ex, full;
        logic [LANES-1:0] m;
        m = 8'b1010_0101;
        for (int i = 0; i < LANES; i++) begin
            full[i] = N'(20'hA0000 + i);
            ex[i]   = m[i] ? N'(20'hA0000 + i) : '0;
        end
        push(1'b0, 16'h0020, full, m);
        LaneMaskM = m;
        MemReadM = 1'b1; MemWriteM = 1'b0;
        ALUResultM[0] = N'(16'h0020);
        record(1'b0, 1'b0, '0, st, dn, rd);
        LaneMaskM = '1;
        tests++;
        if (dn !== 16'h0400) begin fails++; $display("FAIL mask_done: got %h required %h", dn, 16'h0400); end
        tests++;
        if (rd !== ex) begin fails++; $display("FAIL mask_data: got %h required %h", rd, ex); end
        $display("[TB] masked load mask=%b data=%h", m, rd);
    endtask
`endif

    initial begin
        rst = 1'b1;
        MemWriteM = 1'b0;
        MemReadM = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
`ifdef VMEM_LANE_MASK_EN
        LaneMaskM = '1;
`endif
        for (int i = 0; i < LANES; i++) mem[AW'(32 + i)] = N'(20'hA0000 + i);

        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef VMEM_LANE_MASK_EN
        test_mask();
`endif
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d accesses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vec_mem_stage.md
Name: vec_mem_stage

Overview:
- Memory stage directly downstream of Execute.
- Consumes the EX/MEM-registered ALU result (lane 0 is the base address) and the forwarded store data (8 lanes x N bits).
- Performs a vector load or store lane-by-lane through a single-port, N-bit-wide data memory.
- Holds the pipeline via StallM until the whole vector transfer completes, then presents ReadDataM for writeback.

Parameters:
- N, 20, lane width in bits; also the memory word width.
- LANES, 8, lanes per vector.
- AW, 16, memory address width; the address is taken from ALUResultM[0][AW-1:0].

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  vector store request.
- MemReadM  in  1  vector load request.
- ALUResultM  in  [LANES-1:0][N-1:0]  ALU result; lane 0 low AW bits are the base address.
- WriteDataM  in  [LANES-1:0][N-1:0]  store data per lane.
- ReadDataM  out  [LANES-1:0][N-1:0]  load result, valid while DoneM=1 and held until the next load completes.
- StallM  out  1  stalls IF/ID/EX and the EX/MEM register.
- DoneM  out  1  one-cycle pulse when the transfer completes.
- mem_addr  out  AW  memory address.
- mem_wdata  out  N  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  N  read data, valid exactly 1 cycle after mem_re.

Behaviour:
- Reset (async, rst=1): state=IDLE, lane counter=0; ReadDataM=0, StallM=0, DoneM=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0. Asserting reset mid-transfer aborts it immediately; no further mem_we/mem_re pulses occur after rst rises.
- States: IDLE, STORE, LOAD, LOAD_LAST, DONE.
- IDLE:
  - If MemWriteM=1, latch base and WriteDataM, set k=0, go to STORE. MemWriteM has priority if both requests are high; the read is ignored.
  - Else if MemReadM=1, latch base, set k=0, go to LOAD.
  - StallM is combinational and equals MemWriteM|MemReadM in IDLE, so the request's first cycle already stalls.
- STORE:
  - Each cycle: mem_we=1, mem_addr=base+k (mod 2^AW, wrap-around), mem_wdata=lane k; k increments.
  - After k=LANES-1, go to DONE.
  - Store occupies LANES cycles plus DONE.
- LOAD:
  - Each cycle: mem_re=1, mem_addr=base+k (mod 2^AW).
  - mem_rdata arriving in a cycle belongs to lane k-1 and is captured into the internal buffer.
  - After issuing k=LANES-1, go to LOAD_LAST.
- LOAD_LAST: no memory access; capture lane LANES-1, go to DONE.
- DONE:
  - StallM=0, DoneM=1.
  - For a load, ReadDataM is updated from the buffer at entry to DONE.
  - Next state is IDLE; the pipeline advances this cycle, so the request inputs seen in IDLE belong to the next instruction.
- StallM=1 in STORE, LOAD and LOAD_LAST.
- Latency from request to DoneM: store = LANES+1 cycles (9); load = LANES+2 cycles (10).
- Request inputs are ignored outside IDLE; latched copies are used.
- ReadDataM is unchanged by stores.
- mem_we and mem_re are never high in the same cycle.
- Back-to-back requests: an IDLE with a request proceeds immediately; there is no bubble beyond DONE->IDLE.

Optional Feature:
- Macro: VMEM_LANE_MASK_EN.
- With it: adds input LaneMaskM [LANES-1:0], latched in IDLE.
  - Masked-off lanes (bit=0) still consume their cycle, so latency is unchanged.
  - For a masked-off lane, mem_we/mem_re stay low and mem_addr still steps.
  - A masked-off load lane writes 0 into ReadDataM.
- Without it: port absent; all lanes active.

Test Plan:
- Store: base=0x0010, WriteDataM lane i = 0x00100+i, MemWriteM=1 held -> mem_we high 8 cycles at addresses 0x0010..0x0017 with matching data; StallM high cycles 1-8, DoneM pulse at cycle 9, StallM=0 at cycle 9.
- Load: memory preloaded mem[0x0020+i]=0xA0000+i, MemReadM=1 -> mem_re high 8 cycles; ReadDataM lane i = 0xA0000+i at the DoneM pulse (cycle 10); no mem_we.
- Wrap-around: base=0xFFFE store -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005.
- Simultaneous MemWriteM=MemReadM=1 -> store sequence only, mem_re never asserted, ReadDataM unchanged.
- Reset at cycle 4 of a store -> all outputs 0 the same cycle, only 3 writes seen (lanes 0-2); after release, state IDLE and a new load completes normally.
- With VMEM_LANE_MASK_EN, mask=8'b1010_0101 load -> mem_re only on lanes 0, 2, 5, 7; ReadDataM lanes 1, 3, 4, 6 = 0; DoneM still at cycle 10.
